// File: rtl/bit4_sum_accumulator_if.sv
// Handshake bundle between the adder, the accumulator and the downstream logger.
interface bit4_sum_accumulator_if #(
   parameter int ACC_W = 8,
   parameter int CNT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       sum;
   logic             cout;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_total;
   logic             acc_ovf;
   logic [CNT_W-1:0] beat_cnt;

   modport slave (
      input  in_valid, sum, cout, out_ready,
      output in_ready, out_valid, acc_total, acc_ovf, beat_cnt
   );

   modport master (
      output in_valid, sum, cout, out_ready,
      input  in_ready, out_valid, acc_total, acc_ovf, beat_cnt
   );
endinterface

// File: rtl/bit4_sum_accumulator.sv
// Sums COUNT_N 5-bit adder results per block with a sticky wrap flag.
// Result valid 1 cycle after the final beat; input stalls while a block is held.
module bit4_sum_accumulator #(
   parameter int ACC_W   = 8,
   parameter int COUNT_N = 4,
   parameter int CNT_W   = 3
) (
   input  logic clk,
   input  logic rst,
   bit4_sum_accumulator_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovld_q, ovld_d;

   logic [ACC_W:0]   r_ext;
   logic [ACC_W:0]   add;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;

   assign r_ext   = {{(ACC_W-4){1'b0}}, bus.cout, bus.sum};
   assign add     = {1'b0, acc_q} + r_ext;
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign accept  = bus.in_valid && (state_q != HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         ovld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         ovld_q  <= ovld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      ovld_d  = ovld_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               acc_d = r_ext[ACC_W-1:0];
               ovf_d = 1'b0;
               cnt_d = CNT_W'(1);
               if (COUNT_N == 1) begin
                  state_d = HOLD;
                  ovld_d  = 1'b1;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               // Carry out of the truncated sum marks a wrap for the rest of the block.
               acc_d = add[ACC_W-1:0];
               ovf_d = ovf_q | add[ACC_W];
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(COUNT_N)) begin
                  state_d = HOLD;
                  ovld_d  = 1'b1;
               end
            end
         end
         HOLD: begin
            // Totals are left in place after the handshake; the next first beat overwrites them.
            if (bus.out_ready) begin
               ovld_d  = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q != HOLD);
   assign bus.out_valid = ovld_q;
   assign bus.acc_total = acc_q;
   assign bus.acc_ovf   = ovf_q;
   assign bus.beat_cnt  = cnt_q;
endmodule
